// File: rtl/hydra_router.sv
// hydra_router: round-robin arbitration of NUM_PORTS UART RX words onto one
// valid/ready stream, and direction-steered TX fan-out with drop counters.
module hydra_router #(
    parameter int WIDTH     = 64,
    parameter int NUM_PORTS = 4,
    parameter int DIR_BIT   = 62,
    parameter int TIMEOUT   = 48,
    parameter int HOLDOFF   = 2
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [NUM_PORTS-1:0]       enable_posi,
    input  logic [NUM_PORTS-1:0]       enable_piso_upstream,
    input  logic [NUM_PORTS-1:0]       enable_piso_downstream,
    input  logic [NUM_PORTS-1:0]       rx_empty_uart,
    input  logic [NUM_PORTS*WIDTH-1:0] rx_data_uart,
    output logic [NUM_PORTS-1:0]       uld_rx_data_uart,
    output logic [WIDTH-1:0]           rx_data,
    output logic                       rx_valid,
    input  logic                       rx_ready,
    input  logic [WIDTH-1:0]           fifo_data,
    input  logic                       ld_tx_data,
    input  logic [NUM_PORTS-1:0]       tx_busy,
    output logic [NUM_PORTS*WIDTH-1:0] tx_data_uart,
    output logic [NUM_PORTS-1:0]       ld_tx_data_uart,
    output logic [NUM_PORTS-1:0]       rx_enable,
    output logic [NUM_PORTS-1:0]       tx_enable,
    output logic                       tx_ready,
    output logic [7:0]                 rx_drop_count,
    output logic [7:0]                 tx_drop_count,
    input  logic                       clear_counts
);

    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRESENT,
        S_HOLD
    } state_t;

    state_t               state, state_next;
    logic [PW-1:0]        last_grant, grant;
    logic                 grant_found;
    logic [NUM_PORTS-1:0] eligible;
    int unsigned          arb_idx;
    logic [TW-1:0]        tcnt;
    logic [HW-1:0]        hcnt;
    logic                 do_grant, do_leave, do_timeout;
    logic [NUM_PORTS-1:0] tx_mask;
    logic                 tx_accept, tx_drop;

    assign rx_enable = enable_posi;
    assign tx_enable = enable_piso_upstream | enable_piso_downstream;
    assign tx_ready  = ~|tx_busy;
    assign eligible  = enable_posi & ~rx_empty_uart;

    // Search starts one past the previous winner so every port gets a turn.
    always_comb begin
        grant_found = 1'b0;
        grant       = '0;
        arb_idx     = 0;
        for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
            arb_idx = (32'(last_grant) + k) % NUM_PORTS;
            if (!grant_found && eligible[PW'(arb_idx)]) begin
                grant_found = 1'b1;
                grant       = PW'(arb_idx);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_grant   = 1'b0;
        do_leave   = 1'b0;
        do_timeout = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (grant_found) begin
                    do_grant   = 1'b1;
                    state_next = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (rx_ready) begin
                    do_leave = 1'b1;
                end else if (tcnt == TW'(TIMEOUT - 1)) begin
                    do_leave   = 1'b1;
                    do_timeout = 1'b1;
                end
                if (do_leave) state_next = (HOLDOFF == 0) ? S_IDLE : S_HOLD;
            end
            S_HOLD: begin
                if (hcnt == HW'(HOLDOFF - 1)) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data          <= '0;
            rx_valid         <= 1'b0;
            uld_rx_data_uart <= '0;
            last_grant       <= PW'(NUM_PORTS - 1);
            tcnt             <= '0;
            hcnt             <= '0;
        end else begin
            uld_rx_data_uart <= '0;
            if (do_grant) begin
                rx_data                 <= rx_data_uart[grant*WIDTH +: WIDTH];
                uld_rx_data_uart[grant] <= 1'b1;
                rx_valid                <= 1'b1;
                last_grant              <= grant;
                tcnt                    <= '0;
            end
            if (state == S_PRESENT) tcnt <= tcnt + 1'b1;
            if (state == S_HOLD)    hcnt <= hcnt + 1'b1;
            if (do_leave) begin
                rx_valid <= 1'b0;
                tcnt     <= '0;
                hcnt     <= '0;
            end
        end
    end

    assign tx_mask   = fifo_data[DIR_BIT] ? enable_piso_downstream : enable_piso_upstream;
    assign tx_accept = ld_tx_data & tx_ready & (|tx_mask);
    assign tx_drop   = ld_tx_data & ~tx_accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_data_uart    <= '0;
            ld_tx_data_uart <= '0;
        end else begin
            ld_tx_data_uart <= tx_accept ? tx_mask : '0;
            for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                if (tx_accept && tx_mask[i]) tx_data_uart[i*WIDTH +: WIDTH] <= fifo_data;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_drop_count <= '0;
            tx_drop_count <= '0;
        end else if (clear_counts) begin
            rx_drop_count <= '0;
            tx_drop_count <= '0;
        end else begin
            if (do_timeout && rx_drop_count != 8'hFF) rx_drop_count <= rx_drop_count + 1'b1;
            if (tx_drop && tx_drop_count != 8'hFF)    tx_drop_count <= tx_drop_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hydra_router.sv
// Bench for hydra_router: UART queues plus a transaction-level router model,
// directed scenarios followed by randomized traffic.
module tb_hydra_router;

    localparam int W  = 64;
    localparam int NP = 4;
    localparam int DB = 62;
    localparam int TO = 48;
    localparam int HO = 2;

    logic            clk = 1'b0;
    logic            reset_n;
    logic [NP-1:0]   enable_posi, en_up, en_down, rx_empty_uart, uld, tx_busy, ld_uart;
    logic [NP-1:0]   rx_enable, tx_enable;
    logic [NP*W-1:0] rx_data_uart, tx_data_uart;
    logic [W-1:0]    rx_data, fifo_data;
    logic            rx_valid, rx_ready, ld_tx_data, tx_ready, clear_counts;
    logic [7:0]      rx_drop_count, tx_drop_count;

    hydra_router #(.WIDTH(W), .NUM_PORTS(NP), .DIR_BIT(DB), .TIMEOUT(TO), .HOLDOFF(HO)) dut (
        .clk(clk), .reset_n(reset_n), .enable_posi(enable_posi),
        .enable_piso_upstream(en_up), .enable_piso_downstream(en_down),
        .rx_empty_uart(rx_empty_uart), .rx_data_uart(rx_data_uart),
        .uld_rx_data_uart(uld), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .fifo_data(fifo_data), .ld_tx_data(ld_tx_data), .tx_busy(tx_busy),
        .tx_data_uart(tx_data_uart), .ld_tx_data_uart(ld_uart), .rx_enable(rx_enable),
        .tx_enable(tx_enable), .tx_ready(tx_ready), .rx_drop_count(rx_drop_count),
        .tx_drop_count(tx_drop_count), .clear_counts(clear_counts)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // UART RX word queues (circular, depth 8)
    logic [W-1:0] ubuf [NP][8];
    int           ucnt [NP];
    int           uhead[NP];

    // Router model state
    bit           m_valid;
    logic [W-1:0] m_data;
    int           m_age, m_cool, m_last, m_rxd, m_txd;
    logic [NP-1:0] m_uld, m_ld;
    logic [W-1:0] m_tx[NP];

    bit rnd;
    int ready_pct;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input int p, input logic [W-1:0] w);
        if (ucnt[p] < 8) begin
            ubuf[p][(uhead[p] + ucnt[p]) % 8] = w;
            ucnt[p]++;
        end
    endtask

    task automatic drive_uart();
        for (int i = 0; i < NP; i++) begin
            rx_empty_uart[i] = (ucnt[i] == 0);
            rx_data_uart[i*W +: W] = (ucnt[i] > 0) ? ubuf[i][uhead[i]] : 64'hDEAD_BEEF_0BAD_F00D;
        end
    endtask

    task automatic model_reset();
        m_valid = 1'b0;
        m_data  = '0;
        m_age   = 0;
        m_cool  = 0;
        m_last  = NP - 1;
        m_rxd   = 0;
        m_txd   = 0;
        m_uld   = '0;
        m_ld    = '0;
        for (int i = 0; i < NP; i++) m_tx[i] = '0;
    endtask

    // Advance the model across one clock edge using the inputs now applied.
    task automatic model_edge();
        logic [NP-1:0] mask;
        bit inc_rx, inc_tx;
        int p;
        if (!reset_n) return;
        m_uld  = '0;
        m_ld   = '0;
        inc_rx = 1'b0;
        inc_tx = 1'b0;
        if (m_valid) begin
            if (rx_ready) begin
                m_valid = 1'b0;
                m_cool  = HO;
            end else if (m_age == TO) begin
                m_valid = 1'b0;
                m_cool  = HO;
                inc_rx  = 1'b1;
            end else begin
                m_age++;
            end
        end else if (m_cool > 0) begin
            m_cool--;
        end else begin
            for (int k = 1; k <= NP; k++) begin
                p = (m_last + k) % NP;
                if (enable_posi[p] && ucnt[p] > 0) begin
                    m_valid  = 1'b1;
                    m_data   = ubuf[p][uhead[p]];
                    m_age    = 1;
                    m_uld[p] = 1'b1;
                    m_last   = p;
                    break;
                end
            end
        end
        if (ld_tx_data) begin
            mask = fifo_data[DB] ? en_down : en_up;
            if (tx_busy == '0 && mask != '0) begin
                for (int i = 0; i < NP; i++) if (mask[i]) m_tx[i] = fifo_data;
                m_ld = mask;
            end else begin
                inc_tx = 1'b1;
            end
        end
        if (clear_counts) begin
            m_rxd = 0;
            m_txd = 0;
        end else begin
            if (inc_rx && m_rxd < 255) m_rxd++;
            if (inc_tx && m_txd < 255) m_txd++;
        end
    endtask

    always @(negedge clk) begin
        chk("rx_valid", 64'(rx_valid), 64'(m_valid));
        if (m_valid) chk("rx_data", rx_data, m_data);
        chk("uld_rx_data_uart", 64'(uld), 64'(m_uld));
        chk("ld_tx_data_uart", 64'(ld_uart), 64'(m_ld));
        for (int i = 0; i < NP; i++) chk("tx_data_uart", tx_data_uart[i*W +: W], m_tx[i]);
        chk("rx_enable", 64'(rx_enable), 64'(enable_posi));
        chk("tx_enable", 64'(tx_enable), 64'(en_up | en_down));
        chk("tx_ready", 64'(tx_ready), 64'(tx_busy == '0));
        chk("rx_drop_count", 64'(rx_drop_count), 64'(m_rxd));
        chk("tx_drop_count", 64'(tx_drop_count), 64'(m_txd));
    end

    task automatic randomize_env();
        if ($urandom_range(0, 15) == 0) enable_posi = NP'($urandom) | NP'($urandom);
        rx_ready = ($urandom_range(0, 99) < ready_pct);
        if ($urandom_range(0, 2) == 0) push(int'($urandom_range(0, NP - 1)), {$urandom, $urandom});
        en_up        = NP'($urandom);
        en_down      = NP'($urandom);
        tx_busy      = ($urandom_range(0, 3) == 0) ? NP'($urandom) : '0;
        ld_tx_data   = 1'($urandom_range(0, 1));
        fifo_data    = {$urandom, $urandom};
        clear_counts = ($urandom_range(0, 199) == 0);
    endtask

    // One clock: model step, edge, outputs checked at negedge, then UART pops.
    task automatic tick();
        drive_uart();
        model_edge();
        @(posedge clk);
        @(negedge clk);
        #1;
        for (int i = 0; i < NP; i++) begin
            if (uld[i] && ucnt[i] > 0) begin
                uhead[i] = (uhead[i] + 1) % 8;
                ucnt[i]--;
            end
        end
        if (rnd) randomize_env();
        drive_uart();
    endtask

    task automatic apply_reset();
        reset_n      = 1'b0;
        model_reset();
        for (int i = 0; i < NP; i++) begin
            ucnt[i]  = 0;
            uhead[i] = 0;
        end
        enable_posi  = '0;
        en_up        = '0;
        en_down      = '0;
        tx_busy      = '0;
        rx_ready     = 1'b0;
        ld_tx_data   = 1'b0;
        fifo_data    = '0;
        clear_counts = 1'b0;
        tick();
        tick();
        reset_n = 1'b1;
    endtask

    task automatic wait_valid(input logic lvl, input int budget, output int n);
        n = 0;
        while (rx_valid !== lvl && n < budget) begin
            tick();
            n++;
        end
        if (rx_valid !== lvl) chk("wait_rx_valid", 64'(rx_valid), 64'(lvl));
    endtask

    initial begin
        int n, ng, found;
        int gport[5];
        int gtime[5];
        int exp_order[5] = '{0, 1, 2, 3, 0};
        rnd = 1'b0;
        ready_pct = 80;

        // Reset state
        reset_n = 1'b0;
        apply_reset();
        reset_n = 1'b0;
        tick();
        chk("reset_rx_valid", 64'(rx_valid), 64'd0);
        chk("reset_rx_drop", 64'(rx_drop_count), 64'd0);
        chk("reset_tx_drop", 64'(tx_drop_count), 64'd0);
        chk("reset_uld", 64'(uld), 64'd0);
        chk("reset_ld_uart", 64'(ld_uart), 64'd0);
        reset_n = 1'b1;

        // Single word on port 2, accept, then holdoff spacing
        apply_reset();
        enable_posi = '1;
        push(2, 64'hA5);
        tick();
        chk("p2_valid", 64'(rx_valid), 64'd1);
        chk("p2_uld", 64'(uld), 64'b0100);
        chk("p2_data", rx_data, 64'hA5);
        push(2, 64'hB6);
        rx_ready = 1'b1;
        tick();
        chk("p2_after_xfer_valid", 64'(rx_valid), 64'd0);
        chk("p2_holdoff_uld", 64'(uld), 64'd0);
        for (int j = 0; j < HO; j++) begin
            tick();
            chk("p2_holdoff_uld", 64'(uld), 64'd0);
        end
        tick();
        chk("p2_second_uld", 64'(uld), 64'b0100);
        chk("p2_second_data", rx_data, 64'hB6);

        // Round robin with all ports busy and consumer always ready
        apply_reset();
        enable_posi = '1;
        rx_ready = 1'b1;
        for (int p = 0; p < NP; p++) begin
            push(p, 64'h1000 + 64'(p));
            push(p, 64'h2000 + 64'(p));
        end
        push(0, 64'h3000);
        ng = 0;
        for (int t = 1; t <= 40 && ng < 5; t++) begin
            tick();
            if (uld != '0) begin
                found = 0;
                for (int p = 0; p < NP; p++) if (uld[p]) found = p;
                gport[ng] = found;
                gtime[ng] = t;
                ng++;
            end
        end
        chk("rr_grant_count", 64'(ng), 64'd5);
        for (int j = 0; j < 5 && j < ng; j++) begin
            chk("rr_order", 64'(gport[j]), 64'(exp_order[j]));
            if (j > 0) chk("rr_spacing", 64'(gtime[j] - gtime[j-1]), 64'd4);
        end

        // Consumer timeout, saturation, clear
        apply_reset();
        enable_posi = '1;
        push(1, 64'hC0FFEE);
        wait_valid(1'b1, 10, n);
        wait_valid(1'b0, 100, n);
        chk("timeout_len", 64'(n), 64'(TO));
        chk("timeout_drop1", 64'(rx_drop_count), 64'd1);
        for (int r = 0; r < 299; r++) begin
            if (ucnt[1] == 0) push(1, {$urandom, $urandom});
            wait_valid(1'b1, 10, n);
            wait_valid(1'b0, 100, n);
        end
        chk("timeout_saturated", 64'(rx_drop_count), 64'd255);
        clear_counts = 1'b1;
        tick();
        clear_counts = 1'b0;
        chk("timeout_cleared", 64'(rx_drop_count), 64'd0);

        // TX steering and drops
        apply_reset();
        en_down   = 4'b0101;
        en_up     = 4'b1010;
        fifo_data = 64'h4000_0000_0000_1234;
        ld_tx_data = 1'b1;
        tick();
        ld_tx_data = 1'b0;
        chk("tx_down_ld", 64'(ld_uart), 64'b0101);
        chk("tx_down_lane2", tx_data_uart[2*W +: W], 64'h4000_0000_0000_1234);
        fifo_data  = 64'h0000_0000_0000_5678;
        ld_tx_data = 1'b1;
        tick();
        ld_tx_data = 1'b0;
        chk("tx_up_ld", 64'(ld_uart), 64'b1010);
        chk("tx_up_lane1", tx_data_uart[1*W +: W], 64'h5678);
        chk("tx_hold_lane0", tx_data_uart[0 +: W], 64'h4000_0000_0000_1234);
        tx_busy    = 4'b0010;
        ld_tx_data = 1'b1;
        tick();
        ld_tx_data = 1'b0;
        tx_busy    = '0;
        chk("tx_busy_ld", 64'(ld_uart), 64'd0);
        chk("tx_busy_drop", 64'(tx_drop_count), 64'd1);
        en_up      = '0;
        ld_tx_data = 1'b1;
        tick();
        ld_tx_data = 1'b0;
        chk("tx_nomask_ld", 64'(ld_uart), 64'd0);
        chk("tx_nomask_drop", 64'(tx_drop_count), 64'd2);

        // Reset while a word is presented
        apply_reset();
        enable_posi = '1;
        push(2, 64'h77);
        tick();
        chk("mid_rst_grant2", 64'(uld), 64'b0100);
        push(0, 64'h70);
        push(1, 64'h71);
        push(3, 64'h73);
        tick();
        reset_n = 1'b0;
        #1;
        chk("mid_rst_valid", 64'(rx_valid), 64'd0);
        model_reset();
        tick();
        reset_n  = 1'b1;
        rx_ready = 1'b1;
        tick();
        chk("mid_rst_first_grant", 64'(uld), 64'b0001);
        chk("mid_rst_data", rx_data, 64'h70);

        // Randomized traffic
        apply_reset();
        enable_posi = '1;
        rnd = 1'b1;
        ready_pct = 80;
        for (int t = 0; t < 2500; t++) tick();
        ready_pct = 3;
        for (int t = 0; t < 2000; t++) tick();
        ready_pct = 50;
        for (int t = 0; t < 1500; t++) tick();
        rnd = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
